// File: rtl/gpu_scoreboard_pkg.sv
// Shared scoreboard defaults and WMMA group geometry.
// Pure constants: no latency, no backpressure.
package gpu_scoreboard_pkg;
  localparam int GPU_SB_NUM_THREADS = 4;
  localparam int GPU_SB_NUM_REGS    = 16;
  localparam int GPU_SB_CNT_W       = 2;
  localparam int GPU_SB_GROUP       = 4;
  localparam int GPU_SB_GROUP_W     = $clog2(GPU_SB_GROUP);
endpackage

// File: rtl/gpu_scoreboard_if.sv
// ID/WB sideband bundle between decode, writeback and the scoreboard.
// Wires only: no latency; the stall outputs are the backpressure to IF/ID.
interface gpu_scoreboard_if
  import gpu_scoreboard_pkg::*;
#(
  parameter int NUM_THREADS = GPU_SB_NUM_THREADS,
  parameter int NUM_REGS    = GPU_SB_NUM_REGS
);
  localparam int AW = $clog2(NUM_REGS);

  logic [AW-1:0]          rA_addr;
  logic [AW-1:0]          rB_addr;
  logic [AW-1:0]          rD_addr;
  logic                   uses_rA;
  logic                   uses_rB;
  logic                   is_fma;
  logic                   is_st;
  logic                   is_wmma;
  logic                   rf_we;
  logic [NUM_THREADS-1:0] active_mask;
  logic                   issue;
  logic [AW-1:0]          wb_rD_addr;
  logic                   wb_rf_we;
  logic                   wb_is_wmma;
  logic [NUM_THREADS-1:0] wb_active_mask;
  logic                   stall;
  logic                   stall_raw;
  logic                   stall_sat;
  logic                   idle;
  logic                   err_underflow;

  modport master (
    output rA_addr, rB_addr, rD_addr, uses_rA, uses_rB, is_fma, is_st, is_wmma,
           rf_we, active_mask, issue, wb_rD_addr, wb_rf_we, wb_is_wmma, wb_active_mask,
    input  stall, stall_raw, stall_sat, idle, err_underflow
  );

  modport slave (
    input  rA_addr, rB_addr, rD_addr, uses_rA, uses_rB, is_fma, is_st, is_wmma,
           rf_we, active_mask, issue, wb_rD_addr, wb_rf_we, wb_is_wmma, wb_active_mask,
    output stall, stall_raw, stall_sat, idle, err_underflow
  );
endinterface

// File: rtl/gpu_scoreboard_sb_counter_bank.sv
// One thread's in-flight write counters; eff shows the count with this cycle's WB removed.
// Latency: eff combinational, counters update next edge; no backpressure (caller gates inc).
module sb_counter_bank
  import gpu_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = GPU_SB_NUM_REGS,
  parameter int CNT_W    = GPU_SB_CNT_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REGS-1:0]                inc,
  input  logic [NUM_REGS-1:0]                dec,
  output logic [NUM_REGS-1:0][CNT_W-1:0]     eff,
  output logic                               busy,
  output logic                               underflow
);
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (inc[r] && !dec[r]) begin
          cnt[r] <= cnt[r] + 1'b1;
        end else if (dec[r] && !inc[r] && cnt[r] != '0) begin
          cnt[r] <= cnt[r] - 1'b1;
        end
      end
    end
  end

  // Kept apart from the inc-dependent logic so eff never depends on inc.
  always_comb begin
    eff = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      eff[r] = (dec[r] && cnt[r] != '0) ? cnt[r] - 1'b1 : cnt[r];
    end
  end

  always_comb begin
    busy      = 1'b0;
    underflow = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy      = busy | (cnt[r] != '0);
      underflow = underflow | (dec[r] & ~inc[r] & (cnt[r] == '0));
    end
  end
endmodule

// File: rtl/gpu_scoreboard.sv
// Per-thread RAW/saturation scoreboard; GPU_SB_WMMA_EN enables 4-register group operands.
// Latency: 0 for stall, 1 for counter update; stall freezes IF/ID, issue under stall is ignored.
module gpu_scoreboard
  import gpu_scoreboard_pkg::*;
#(
  parameter int NUM_THREADS = GPU_SB_NUM_THREADS,
  parameter int NUM_REGS    = GPU_SB_NUM_REGS,
  parameter int CNT_W       = GPU_SB_CNT_W
) (
  input logic             clk,
  input logic             rst,
  gpu_scoreboard_if.slave sb
);
  localparam int               AW       = $clog2(NUM_REGS);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [NUM_REGS-1:0] set_a, set_b, set_d, set_wb, rd_set;
  logic                rd_read;

`ifdef GPU_SB_WMMA_EN
  function automatic logic [NUM_REGS-1:0] reg_set(input logic [AW-1:0] addr, input logic grp);
    logic [NUM_REGS-1:0] s;
    s = '0;
    if (grp) begin
      for (int i = 0; i < GPU_SB_GROUP; i++) begin
        s[{addr[AW-1:GPU_SB_GROUP_W], GPU_SB_GROUP_W'(i)}] = 1'b1;
      end
    end else begin
      s[addr] = 1'b1;
    end
    return s;
  endfunction

  assign set_a   = reg_set(sb.rA_addr, sb.is_wmma);
  assign set_b   = reg_set(sb.rB_addr, sb.is_wmma);
  assign set_d   = reg_set(sb.rD_addr, sb.is_wmma);
  assign set_wb  = reg_set(sb.wb_rD_addr, sb.wb_is_wmma);
  // WMMA accumulates into its destination group, so rD is also a source.
  assign rd_read = sb.is_fma | sb.is_st | (sb.is_wmma & sb.rf_we);
`else
  logic unused_wmma;
  assign unused_wmma = sb.is_wmma ^ sb.wb_is_wmma;
  assign set_a   = NUM_REGS'(1) << sb.rA_addr;
  assign set_b   = NUM_REGS'(1) << sb.rB_addr;
  assign set_d   = NUM_REGS'(1) << sb.rD_addr;
  assign set_wb  = NUM_REGS'(1) << sb.wb_rD_addr;
  assign rd_read = sb.is_fma | sb.is_st;
`endif

  assign rd_set = ({NUM_REGS{sb.uses_rA}} & set_a) |
                  ({NUM_REGS{sb.uses_rB}} & set_b) |
                  ({NUM_REGS{rd_read}}    & set_d);

  logic [NUM_THREADS-1:0]                          raw, sat, inc_en, dec_en, busy, uf;
  logic [NUM_THREADS-1:0][NUM_REGS-1:0][CNT_W-1:0] eff;
  logic                                            err_q;

  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thr
    sb_counter_bank #(
      .NUM_REGS (NUM_REGS),
      .CNT_W    (CNT_W)
    ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .inc       (set_d  & {NUM_REGS{inc_en[t]}}),
      .dec       (set_wb & {NUM_REGS{dec_en[t]}}),
      .eff       (eff[t]),
      .busy      (busy[t]),
      .underflow (uf[t])
    );
  end

  always_comb begin
    raw = '0;
    sat = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (rd_set[r] && eff[t][r] != '0) raw[t] = 1'b1;
        if (sb.rf_we && set_d[r] && eff[t][r] == CNT_MAX) sat[t] = 1'b1;
      end
    end
  end

  assign sb.stall_raw = |(sb.active_mask & raw);
  assign sb.stall_sat = |(sb.active_mask & sat);
  assign sb.stall     = sb.stall_raw | sb.stall_sat;

  assign inc_en = {NUM_THREADS{sb.issue & sb.rf_we & ~sb.stall}} & sb.active_mask;
  assign dec_en = {NUM_THREADS{sb.wb_rf_we}} & sb.wb_active_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (|uf) begin
      err_q <= 1'b1;
    end
  end

  assign sb.err_underflow = err_q;
  assign sb.idle          = ~|busy;
endmodule

// File: tb/tb_gpu_scoreboard.sv
// Directed test-plan scenarios then random traffic, checked against a count-per-register model.
module tb_gpu_scoreboard;
  localparam int NT   = 4;
  localparam int NR   = 16;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;
`ifdef GPU_SB_WMMA_EN
  localparam bit WMMA_ON = 1'b1;
`else
  localparam bit WMMA_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  initial forever #5 clk = ~clk;

  gpu_scoreboard_if #(.NUM_THREADS(NT), .NUM_REGS(NR)) sb ();

  gpu_scoreboard #(.NUM_THREADS(NT), .NUM_REGS(NR), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cnt_m[NT][NR];
  bit err_m;
  bit exp_raw, exp_sat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_set(int r, int a, bit g);
    return g ? (r / 4 == a / 4) : (r == a);
  endfunction

  function automatic int eff_m(int t, int r);
    bit gwb = WMMA_ON && sb.wb_is_wmma;
    if (sb.wb_rf_we && sb.wb_active_mask[t] && in_set(r, int'(sb.wb_rD_addr), gwb) && cnt_m[t][r] > 0)
      return cnt_m[t][r] - 1;
    return cnt_m[t][r];
  endfunction

  function automatic bit idle_m();
    for (int t = 0; t < NT; t++)
      for (int r = 0; r < NR; r++)
        if (cnt_m[t][r] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic predict();
    bit g   = WMMA_ON && sb.is_wmma;
    bit rdd = sb.is_fma || sb.is_st || (g && sb.rf_we);
    exp_raw = 1'b0;
    exp_sat = 1'b0;
    for (int t = 0; t < NT; t++) begin
      if (!sb.active_mask[t]) continue;
      for (int r = 0; r < NR; r++) begin
        int e = eff_m(t, r);
        bit rd = (sb.uses_rA && in_set(r, int'(sb.rA_addr), g)) ||
                 (sb.uses_rB && in_set(r, int'(sb.rB_addr), g)) ||
                 (rdd && in_set(r, int'(sb.rD_addr), g));
        if (rd && e > 0) exp_raw = 1'b1;
        if (sb.rf_we && in_set(r, int'(sb.rD_addr), g) && e == CMAX) exp_sat = 1'b1;
      end
    end
  endtask

  task automatic update_model();
    bit g   = WMMA_ON && sb.is_wmma;
    bit gwb = WMMA_ON && sb.wb_is_wmma;
    bit st  = exp_raw | exp_sat;
    if (rst) begin
      for (int t = 0; t < NT; t++)
        for (int r = 0; r < NR; r++) cnt_m[t][r] = 0;
      err_m = 1'b0;
      return;
    end
    for (int t = 0; t < NT; t++) begin
      for (int r = 0; r < NR; r++) begin
        bit inc = sb.issue && sb.rf_we && !st && sb.active_mask[t] && in_set(r, int'(sb.rD_addr), g);
        bit dec = sb.wb_rf_we && sb.wb_active_mask[t] && in_set(r, int'(sb.wb_rD_addr), gwb);
        if (inc && !dec) cnt_m[t][r]++;
        else if (dec && !inc) begin
          if (cnt_m[t][r] > 0) cnt_m[t][r]--;
          else err_m = 1'b1;
        end
      end
    end
  endtask

  task automatic settle();
    #4;
    predict();
    check("stall_raw", sb.stall_raw, exp_raw);
    check("stall_sat", sb.stall_sat, exp_sat);
    check("stall", sb.stall, exp_raw | exp_sat);
    check("idle", sb.idle, idle_m());
    check("err_underflow", sb.err_underflow, err_m);
  endtask

  task automatic tick();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic clear_in();
    sb.rA_addr = '0; sb.rB_addr = '0; sb.rD_addr = '0;
    sb.uses_rA = 1'b0; sb.uses_rB = 1'b0; sb.is_fma = 1'b0; sb.is_st = 1'b0;
    sb.is_wmma = 1'b0; sb.rf_we = 1'b0; sb.active_mask = '0; sb.issue = 1'b0;
    sb.wb_rD_addr = '0; sb.wb_rf_we = 1'b0; sb.wb_is_wmma = 1'b0; sb.wb_active_mask = '0;
  endtask

  task automatic wb(input int rd, input logic [NT-1:0] m);
    clear_in();
    sb.wb_rf_we = 1'b1; sb.wb_rD_addr = 4'(rd); sb.wb_active_mask = m;
  endtask

  initial begin
    for (int t = 0; t < NT; t++)
      for (int r = 0; r < NR; r++) cnt_m[t][r] = 0;
    err_m = 1'b0;
    clear_in();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    settle();
    check("rst_idle", sb.idle, 1);
    check("rst_err", sb.err_underflow, 0);
    check("rst_stall", sb.stall, 0);
    tick();

    // RAW on R3 held until its WB, released in the WB cycle
    sb.rf_we = 1'b1; sb.rD_addr = 4'd3; sb.active_mask = 4'hF; sb.issue = 1'b1;
    settle(); tick();
    sb.rD_addr = 4'd1; sb.uses_rA = 1'b1; sb.rA_addr = 4'd3;
    repeat (2) begin settle(); check("raw_r3", sb.stall_raw, 1); tick(); end
    sb.wb_rf_we = 1'b1; sb.wb_rD_addr = 4'd3; sb.wb_active_mask = 4'hF;
    settle(); check("raw_bypass", sb.stall_raw, 0); tick();
    wb(1, 4'hF); settle(); tick();
    clear_in(); settle(); check("idle_raw", sb.idle, 1); tick();

    // saturation on R5, WB bypass and inc+dec hold at max
    sb.rf_we = 1'b1; sb.issue = 1'b1; sb.rD_addr = 4'd5; sb.active_mask = 4'h1;
    repeat (3) begin settle(); check("sat_free", sb.stall_sat, 0); tick(); end
    settle(); check("sat_full", sb.stall_sat, 1); tick();
    sb.wb_rf_we = 1'b1; sb.wb_rD_addr = 4'd5; sb.wb_active_mask = 4'h1;
    settle(); check("sat_bypass", sb.stall_sat, 0); tick();
    sb.wb_rf_we = 1'b0;
    settle(); check("sat_held", sb.stall_sat, 1); tick();
    wb(5, 4'h1); repeat (3) begin settle(); tick(); end
    clear_in(); settle(); check("idle_sat", sb.idle, 1); tick();

    // per-thread masking
    sb.rf_we = 1'b1; sb.issue = 1'b1; sb.rD_addr = 4'd2; sb.active_mask = 4'b0011;
    settle(); tick();
    clear_in(); sb.uses_rA = 1'b1; sb.rA_addr = 4'd2; sb.issue = 1'b1; sb.active_mask = 4'b1100;
    settle(); check("mask_disjoint", sb.stall_raw, 0); tick();
    sb.active_mask = 4'b0101;
    settle(); check("mask_overlap", sb.stall_raw, 1); tick();
    wb(2, 4'b0011); settle(); tick();
    clear_in(); settle(); check("idle_mask", sb.idle, 1); tick();

    // same-cycle inc and dec on R4
    sb.rf_we = 1'b1; sb.issue = 1'b1; sb.rD_addr = 4'd4; sb.active_mask = 4'h1;
    settle(); tick();
    sb.wb_rf_we = 1'b1; sb.wb_rD_addr = 4'd4; sb.wb_active_mask = 4'h1;
    settle(); check("incdec_stall", sb.stall, 0); tick();
    clear_in(); settle(); check("incdec_busy", sb.idle, 0); tick();
    wb(4, 4'h1); settle(); tick();
    clear_in(); settle(); check("idle_incdec", sb.idle, 1); tick();

    // WMMA group tracking (ignored when the feature is compiled out)
    sb.is_wmma = 1'b1; sb.rf_we = 1'b1; sb.rD_addr = 4'd8; sb.active_mask = 4'hF; sb.issue = 1'b1;
    settle(); check("wmma_issue", sb.stall, 0); tick();
    clear_in(); sb.uses_rA = 1'b1; sb.rA_addr = 4'd10; sb.active_mask = 4'hF; sb.issue = 1'b1;
    settle(); check("wmma_raw", sb.stall_raw, WMMA_ON ? 1 : 0); tick();
    if (WMMA_ON) begin
      wb(9, 4'hF); sb.wb_is_wmma = 1'b1;
    end else begin
      wb(8, 4'hF);
    end
    settle(); tick();
    clear_in(); settle(); check("wmma_idle", sb.idle, 1); tick();

    // underflow is sticky until reset
    wb(7, 4'h1); settle(); tick();
    clear_in(); settle(); check("uf_set", sb.err_underflow, 1); tick();
    settle(); check("uf_sticky", sb.err_underflow, 1); tick();
    rst = 1'b1; settle(); tick();
    rst = 1'b0; settle();
    check("uf_rst", sb.err_underflow, 0);
    check("idle_rst", sb.idle, 1);
    tick();

    for (int i = 0; i < 1500; i++) begin
      rst               = ($urandom_range(0, 199) == 0);
      sb.rA_addr        = 4'($urandom_range(0, 7));
      sb.rB_addr        = 4'($urandom_range(0, 7));
      sb.rD_addr        = 4'($urandom_range(0, 7));
      sb.uses_rA        = ($urandom_range(0, 1) == 0);
      sb.uses_rB        = ($urandom_range(0, 2) == 0);
      sb.is_fma         = ($urandom_range(0, 5) == 0);
      sb.is_st          = ($urandom_range(0, 9) == 0);
      sb.is_wmma        = ($urandom_range(0, 7) == 0);
      sb.rf_we          = ($urandom_range(0, 3) != 0);
      sb.active_mask    = 4'($urandom);
      sb.issue          = ($urandom_range(0, 4) != 0);
      sb.wb_rD_addr     = 4'($urandom_range(0, 7));
      sb.wb_rf_we       = ($urandom_range(0, 2) == 0);
      sb.wb_is_wmma     = ($urandom_range(0, 7) == 0);
      sb.wb_active_mask = 4'($urandom);
      settle();
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
